// File: rtl/volume_ramp_if.sv
// volume_ramp_if: control/status bundle of volume_ramp; mute exists only with VOLUME_RAMP_MUTE_EN
interface volume_ramp_if #(parameter int VOLUME_BITS = 4);
  logic                   sample_valid;
  logic                   target_load;
  logic [VOLUME_BITS-1:0] target_volume;
  logic [VOLUME_BITS-1:0] volume;
  logic                   ramping;
  logic                   muted;
`ifdef VOLUME_RAMP_MUTE_EN
  logic                   mute;
`endif
  modport master (
`ifdef VOLUME_RAMP_MUTE_EN
    output mute,
`endif
    output sample_valid, target_load, target_volume,
    input  volume, ramping, muted
  );
  modport slave (
`ifdef VOLUME_RAMP_MUTE_EN
    input  mute,
`endif
    input  sample_valid, target_load, target_volume,
    output volume, ramping, muted
  );
endinterface

// File: rtl/volume_ramp.sv
// volume_ramp: zipper-free volume stepping paced by sample strobes; mute fade with VOLUME_RAMP_MUTE_EN
module volume_ramp #(
  parameter int VOLUME_BITS = 4,
  parameter int STEP_DIV    = 16
) (
  input logic          clk,
  input logic          rst_n,
  volume_ramp_if.slave bus
);
  localparam int DW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(STEP_DIV - 1);
  typedef enum logic [1:0] {IDLE, RAMP, MUTED} state_t;
  state_t                 r_state, w_nxt;
  logic [VOLUME_BITS-1:0] r_target, r_volume, w_eff, w_vol_nxt;
  logic [DW-1:0]          r_div;
  logic                   r_ramping, r_muted, w_mute, w_step;
`ifdef VOLUME_RAMP_MUTE_EN
  assign w_mute = bus.mute;
`else
  assign w_mute = 1'b0;
`endif
  assign bus.volume  = r_volume;
  assign bus.ramping = r_ramping;
  assign bus.muted   = r_muted;
  // The step always uses the target held before this edge; a same-cycle load applies next cycle.
  always_comb begin
    w_eff     = w_mute ? '0 : r_target;
    w_step    = r_state == RAMP && bus.sample_valid && r_div == DIV_MAX;
    w_vol_nxt = !w_step ? r_volume :
                r_volume < w_eff ? r_volume + 1'b1 :
                r_volume > w_eff ? r_volume - 1'b1 : r_volume;
    w_nxt     = r_state;
    case (r_state)
      IDLE:    w_nxt = (w_mute && r_volume == '0) ? MUTED : (w_eff != r_volume) ? RAMP : IDLE;
      RAMP:    w_nxt = (w_vol_nxt != w_eff) ? RAMP : w_mute ? MUTED : IDLE;
      default: w_nxt = w_mute ? MUTED : (r_target != '0) ? RAMP : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= IDLE;
      r_target  <= '0;
      r_volume  <= '0;
      r_div     <= '0;
      r_ramping <= 1'b0;
      r_muted   <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_target  <= bus.target_load ? bus.target_volume : r_target;
      r_volume  <= w_vol_nxt;
      r_div     <= w_nxt != RAMP ? '0 :
                   (r_state == RAMP && bus.sample_valid) ? (r_div == DIV_MAX ? '0 : r_div + 1'b1) : r_div;
      r_ramping <= w_nxt == RAMP;
      r_muted   <= w_nxt == MUTED;
    end
endmodule

// File: doc/volume_ramp.md
# volume_ramp

Generates the volume index that drives the sample scaler in the audio output path. It moves the applied volume one step at a time toward a software-written target. Steps are paced by the audio sample strobe, so gain changes never jump and cause zipper noise. An optional mute fades the volume to zero and back.

## Interface
- `VOLUME_BITS`, 4: width of the volume index. `2**VOLUME_BITS - 1` is full scale, matching the scaler's index width.
- `STEP_DIV`, 16: number of `sample_valid` pulses per one-LSB volume step. Legal range is ≥1.
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `sample_valid` input 1: one-cycle strobe per audio sample. Pacing only.
- `target_volume` input `VOLUME_BITS`: new target, sampled when `target_load` is high.
- `target_load` input 1: one-cycle load strobe for `target_volume`.
- `mute` input 1: level-sensitive mute request. Present only with the configuration macro (see Configuration).
- `volume` output `VOLUME_BITS`: registered volume index to the scaler.
- `ramping` output 1: high while `volume` is moving.
- `muted` output 1: high while mute is active and `volume == 0`.

## Operation
- Registers:
  - `target_q`: holds the loaded target.
  - `volume`: the current index.
  - `div_cnt`: counts from 0 to `STEP_DIV-1`, `$clog2(STEP_DIV)` bits wide, minimum 1 bit.
  - `state`.
- Effective target is `eff = mute ? 0 : target_q`. Without mute compiled in, `eff = target_q`.
- States:
  - `IDLE`: `volume == eff` and not muted. `div_cnt` is held at 0.
  - `RAMP`: `volume != eff`. `div_cnt` increments on each `sample_valid`.
  - `MUTED`: mute asserted and `volume == 0`. `div_cnt` is held at 0.
- Step event: `sample_valid` high and `div_cnt == STEP_DIV-1` while in `RAMP`.
  - On a step event, `div_cnt` returns to 0.
  - `volume` moves by exactly 1 toward `eff`.
  - The arithmetic is unsigned. `volume` never overshoots `eff` and never wraps past 0 or full scale.
- Transitions:
  - `IDLE`→`RAMP` when `eff != volume`.
  - `RAMP`→`IDLE` on the edge where `volume` reaches `eff` with mute low.
  - `RAMP`→`MUTED` on the edge where `volume` reaches 0 with mute high.
  - `IDLE`→`MUTED` directly if mute is asserted while `volume` is already 0.
  - `MUTED`→`RAMP` on mute deassertion when `target_q != 0`.
  - `MUTED`→`IDLE` on mute deassertion when `target_q == 0`.
- Boundary behaviour:
  - **Load during `RAMP`:** `target_q` updates. `div_cnt` is not cleared, so the pacing phase is preserved. Direction reverses on the next step if needed.
  - **Load and step event in the same cycle:** the step uses the old `target_q`. The new target applies from the next cycle.
  - **Load equal to current `volume`:** stays in, or returns to, `IDLE` with no step.
  - **`STEP_DIV == 1`:** every `sample_valid` in `RAMP` is a step.
  - **Mute toggled mid-ramp:** `eff` switches immediately and direction follows on the next step.
  - **Reset mid-ramp:** all registers clear immediately. No fade-out on reset.

## Timing
- Reset values:
  - `volume = 0`, `ramping = 0`, `muted = 0`.
  - `target_q = 0`, `div_cnt = 0`, `state = IDLE`.
- All outputs are registered and update on the rising `clk` edge.
- `target_load` edge to `ramping` high: 1 cycle. `state` enters `RAMP` on the edge after capture.
- A step event is visible on `volume` immediately after the edge that sampled it.
- `ramping` falls, and `muted` rises, on the same edge where `volume` reaches its final value.
- Full-scale ramp (0 to `2**VOLUME_BITS-1`) takes `(2**VOLUME_BITS-1)*STEP_DIV` sample strobes.
- `target_load` and `sample_valid` are single-cycle. Back-to-back loads are legal; the last one wins.

## Configuration
- Macro: `VOLUME_RAMP_MUTE_EN`.
- **Defined:**
  - The `mute` port exists.
  - `eff` includes mute.
  - The `MUTED` state and the `muted` output are active.
- **Undefined:**
  - The `mute` port is absent.
  - `eff = target_q`.
  - `MUTED` is unreachable.
  - `muted` is tied to 0.

## Test plan
All tests use `VOLUME_BITS=4`, `STEP_DIV=4`, with `sample_valid` pulsed every 8 cycles.
- **Reset:** hold `rst_n` low, then release → `volume=0`, `ramping=0`, `muted=0`. Pulse `sample_valid` 20 times with no load → `volume` stays 0.
- **Ramp up:** load 8 from 0 → `ramping` rises 1 cycle later. `volume` increments every 4th strobe and reaches 8 after 32 strobes. `ramping` falls on that edge. No value exceeds 8.
- **Reversal:** load 15 from 0, wait 20 strobes (`volume=5`), then load 2 → next step gives 4. `volume` reaches 2 after 8 further strobes and holds.
- **Simultaneous events:** at `volume=3` ramping toward 10, assert `target_load` with value 0 on a step-event cycle → `volume` becomes 4, then steps down to 0.
- **Mute (`VOLUME_RAMP_MUTE_EN`):** at `volume=6` in `IDLE`, raise `mute` → `volume` reaches 0 after 24 strobes and `muted=1`. Lower `mute` → `muted=0` next edge, and `volume` returns to 6 after 24 strobes.
- **Reset mid-ramp:** assert `rst_n=0` asynchronously at `volume=7` → `volume=0` and `ramping=0` without waiting for a clock edge.
